// File: rtl/prog_mem_arbiter.sv
// Program memory arbiter: CPU fetch has priority, debug port gets a guaranteed slot after MAX_WAIT denials.
// Optional feature macro PROG_MEM_WRITE_EN enables debug writes; without it writes are rejected with DBG_ERR.
module prog_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_FETCH,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic              CPU_STALL,
  output logic [DATA_W-1:0] CPU_IR,
  output logic              CPU_IR_VLD,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic              DBG_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, DBG_RD, DBG_WR, ACK_WAIT} state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
`ifdef PROG_MEM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              cpu_vld_q, cpu_vld_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              wr_reject;
  logic              dbg_grant;
  logic              dbg_mem;
  logic              cpu_grant;
  logic [ADDR_W-1:0] mem_addr;

  // A rejected write never touches the memory, so it can be granted alongside a CPU fetch.
  assign wr_reject = DBG_WE && !WR_EN;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_grant   = 1'b0;
    dbg_mem     = 1'b0;
    cpu_grant   = 1'b0;
    mem_addr    = '0;
    // NOTE: the combinational grant path is gated by RST so that every output reads 0 while in reset,
    // not just the registered ones.
    if (!RST) begin
      if (state_q == IDLE && DBG_REQ &&
          (wr_reject || !CPU_FETCH || wait_cnt_q == MAX_WAIT_C)) begin
        dbg_grant = 1'b1;
      end
      dbg_mem   = dbg_grant && !wr_reject;
      cpu_grant = CPU_FETCH && !dbg_mem;

      if (dbg_mem)        mem_addr = DBG_ADDR;
      else if (cpu_grant) mem_addr = CPU_ADDR;

      if (dbg_grant) begin
        wait_cnt_d = '0;
      end else if (state_q == IDLE && DBG_REQ && wait_cnt_q != MAX_WAIT_C) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      IDLE:     if (dbg_grant) state_d = DBG_WE ? DBG_WR : DBG_RD;
      DBG_RD: begin
        dbg_rdata_d = MEM_RDATA;
        state_d     = ACK_WAIT;
      end
      DBG_WR:   state_d = ACK_WAIT;
      ACK_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign cpu_vld_d = cpu_grant;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cpu_vld_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_vld_q   <= cpu_vld_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign CPU_STALL  = CPU_FETCH && !cpu_grant && !RST;
  assign CPU_IR_VLD = cpu_vld_q;
  assign CPU_IR     = cpu_vld_q ? MEM_RDATA : '0;
  assign DBG_ACK    = (state_q == DBG_RD) || (state_q == DBG_WR);
  assign DBG_ERR    = (state_q == DBG_WR) && !WR_EN;
  // Read data is forwarded straight from memory in the ack cycle and held afterwards.
  assign DBG_RDATA  = (state_q == DBG_RD) ? MEM_RDATA : dbg_rdata_q;
  assign MEM_ADDR   = mem_addr;

`ifdef PROG_MEM_WRITE_EN
  assign MEM_WE    = dbg_mem && DBG_WE;
  assign MEM_WDATA = (dbg_mem && DBG_WE) ? DBG_WDATA : '0;
`else
  logic unused_wdata;
  assign unused_wdata = ^DBG_WDATA;
  assign MEM_WE       = 1'b0;
  assign MEM_WDATA    = '0;
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural program memory.
module tb_prog_mem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 18;
  localparam int MAX_WAIT = 8;
`ifdef PROG_MEM_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              CPU_FETCH;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic              CPU_STALL;
  logic [DATA_W-1:0] CPU_IR;
  logic              CPU_IR_VLD;
  logic              DBG_REQ;
  logic              DBG_WE;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic [DATA_W-1:0] DBG_WDATA;
  logic              DBG_ACK;
  logic [DATA_W-1:0] DBG_RDATA;
  logic              DBG_ERR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA = '0;

  prog_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_FETCH(CPU_FETCH), .CPU_ADDR(CPU_ADDR), .CPU_STALL(CPU_STALL),
    .CPU_IR(CPU_IR), .CPU_IR_VLD(CPU_IR_VLD),
    .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
    .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA), .DBG_ERR(DBG_ERR),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural program memory seen by the DUT (synchronous read, read-before-write).
  logic [DATA_W-1:0] mem      [1024];
  logic [DATA_W-1:0] init_mem [1024];
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= mem[MEM_ADDR];
  end

  int we_cnt = 0;
  always @(negedge CLK) if (MEM_WE) we_cnt++;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [1024];
  bit                m_ack_due, m_ack_rd, m_ack_err, m_cool, m_ir_due;
  logic [DATA_W-1:0] m_ack_data, m_rdata_hold, m_ir_val;
  int                m_denied;
  bit                n_valid, n_ack_due, n_ack_rd, n_ack_err, n_ir_due, n_wr;
  logic [DATA_W-1:0] n_ack_data, n_ir_val, n_wr_data;
  logic [ADDR_W-1:0] n_wr_addr;
  int                n_denied;

  always @(negedge CLK) begin
    bit wr_rej, eligible, dbg_win, dbg_mem, cpu_win;
    if (RST) begin
      m_ack_due = 0; m_ack_rd = 0; m_ack_err = 0; m_cool = 0; m_ir_due = 0;
      m_denied = 0; m_rdata_hold = '0; n_valid = 0;
      check("rst_stall", CPU_STALL, 0);
      check("rst_ir_vld", CPU_IR_VLD, 0);
      check("rst_ir", CPU_IR, 0);
      check("rst_ack", DBG_ACK, 0);
      check("rst_err", DBG_ERR, 0);
      check("rst_rdata", DBG_RDATA, 0);
      check("rst_we", MEM_WE, 0);
      check("rst_addr", MEM_ADDR, 0);
    end else begin
      wr_rej   = DBG_WE && !WEN;
      eligible = !m_ack_due && !m_cool;
      dbg_win  = eligible && DBG_REQ && (wr_rej || !CPU_FETCH || m_denied >= MAX_WAIT);
      dbg_mem  = dbg_win && !wr_rej;
      cpu_win  = CPU_FETCH && !dbg_mem;

      check("stall", CPU_STALL, CPU_FETCH && !cpu_win);
      check("mem_we", MEM_WE, dbg_mem && DBG_WE);
      if (dbg_mem) check("mem_addr_dbg", MEM_ADDR, DBG_ADDR);
      else if (cpu_win) check("mem_addr_cpu", MEM_ADDR, CPU_ADDR);
      if (dbg_mem && DBG_WE) check("mem_wdata", MEM_WDATA, DBG_WDATA);
      if (!WEN) check("mem_wdata_tied", MEM_WDATA, 0);
      check("ir_vld", CPU_IR_VLD, m_ir_due);
      if (m_ir_due) check("ir", CPU_IR, m_ir_val);
      check("ack", DBG_ACK, m_ack_due);
      if (m_ack_due) check("err", DBG_ERR, m_ack_err);
      if (m_ack_due && m_ack_rd) begin
        check("rdata", DBG_RDATA, m_ack_data);
        m_rdata_hold = m_ack_data;
      end else begin
        check("rdata_hold", DBG_RDATA, m_rdata_hold);
      end

      n_ack_due  = dbg_win;
      n_ack_rd   = dbg_win && !DBG_WE;
      n_ack_err  = dbg_win && wr_rej;
      n_ack_data = ref_mem[DBG_ADDR];
      n_ir_due   = cpu_win;
      n_ir_val   = ref_mem[CPU_ADDR];
      n_wr       = dbg_mem && DBG_WE;
      n_wr_addr  = DBG_ADDR;
      n_wr_data  = DBG_WDATA;
      if (dbg_win) n_denied = 0;
      else if (eligible && DBG_REQ) n_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
      else n_denied = m_denied;
      n_valid = 1;
    end
  end

  always @(posedge CLK) begin
    if (n_valid) begin
      m_cool     = m_ack_due;
      m_ack_due  = n_ack_due;
      m_ack_rd   = n_ack_rd;
      m_ack_err  = n_ack_err;
      m_ack_data = n_ack_data;
      m_ir_due   = n_ir_due;
      m_ir_val   = n_ir_val;
      m_denied   = n_denied;
      if (n_wr) ref_mem[n_wr_addr] = n_wr_data;
      n_valid = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    CPU_FETCH = 0; DBG_REQ = 0;
    repeat (n) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int free_cnt, w0, ack_a, ack_b, ack_n, hold, cyc;
    bit got, pending;
    for (int i = 0; i < 1024; i++) begin
      mem[i]      = DATA_W'($urandom);
      init_mem[i] = mem[i];
      ref_mem[i]  = mem[i];
    end
    RST = 1; CPU_FETCH = 1; CPU_ADDR = 10'h005;
    DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = '0; DBG_WDATA = '0;
    repeat (3) step();

    // reset release with a pending fetch of 0x005
    RST = 0;
    @(negedge CLK);
    check("post_rst_addr", MEM_ADDR, 10'h005);
    step(); CPU_FETCH = 0;
    @(negedge CLK);
    check("post_rst_vld", CPU_IR_VLD, 1);
    check("post_rst_ir", CPU_IR, init_mem[5]);
    idle_cycles(2);

    // starvation: continuous fetch, debug read of 0x3FF
    CPU_FETCH = 1; CPU_ADDR = 10'($urandom_range(0, 1022));
    DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 10'h3FF;
    free_cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (CPU_STALL) got = 1;
      else free_cnt++;
      step();
      CPU_ADDR = 10'($urandom_range(0, 1022));
    end
    check("starve_stalled", got, 1);
    check("starve_free_fetches", free_cnt, MAX_WAIT);
    @(negedge CLK);
    check("starve_ack", DBG_ACK, 1);
    check("starve_rdata", DBG_RDATA, init_mem[10'h3FF]);
    step(); DBG_REQ = 0;
    idle_cycles(2);

    // debug write of 0x010 with CPU idle, then fetch it back
    w0 = we_cnt;
    DBG_REQ = 1; DBG_WE = 1; DBG_ADDR = 10'h010; DBG_WDATA = 18'h2ABCD;
    @(negedge CLK);
    check("wr_we_grant", MEM_WE, WEN);
    step();
    @(negedge CLK);
    check("wr_ack", DBG_ACK, 1);
    check("wr_err", DBG_ERR, !WEN);
    check("wr_we_after", MEM_WE, 0);
    step(); DBG_REQ = 0; DBG_WE = 0; CPU_FETCH = 1; CPU_ADDR = 10'h010;
    step(); CPU_FETCH = 0;
    @(negedge CLK);
    check("wr_fetch_vld", CPU_IR_VLD, 1);
    check("wr_fetch_ir", CPU_IR, WEN ? 18'h2ABCD : init_mem[10'h010]);
    check("wr_we_pulses", we_cnt - w0, WEN ? 1 : 0);
    idle_cycles(2);

    // reset during DBG_RD aborts; re-request completes
    DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 10'h123;
    step(); RST = 1;
    @(negedge CLK);
    check("abort_ack", DBG_ACK, 0);
    check("abort_wait_cnt", dut.wait_cnt_q, 0);
    step(); step(); RST = 0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge CLK);
      if (DBG_ACK) got = 1;
      else step();
    end
    check("rereq_ack", got, 1);
    check("rereq_rdata", DBG_RDATA, ref_mem[10'h123]);
    step(); DBG_REQ = 0;
    idle_cycles(2);

    // DBG_REQ held through ACK: next ack three cycles after the first
    DBG_REQ = 1; DBG_WE = 0; DBG_ADDR = 10'h055;
    ack_a = -1; ack_b = -1; ack_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DBG_ACK) begin
        if (ack_n == 0) ack_a = i;
        else if (ack_n == 1) ack_b = i;
        ack_n++;
      end
      step();
    end
    check("held_ack_gap", ack_b - ack_a, 3);
    DBG_REQ = 0;
    idle_cycles(2);

    // randomized traffic
    pending = 0; hold = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      got = DBG_ACK;
      step();
      if (RST) RST = 0;
      else if ($urandom_range(0, 499) == 0) RST = 1;
      CPU_FETCH = ($urandom_range(0, 9) < 7);
      CPU_ADDR  = 10'($urandom_range(0, 15));
      if (pending && got) begin
        pending = 0; hold = 0; DBG_REQ = 0;
      end
      if (pending) begin
        hold++;
        if (hold > 40) begin
          check("dbg_timeout", hold, 40);
          pending = 0; hold = 0; DBG_REQ = 0;
        end
      end
      if (!pending && $urandom_range(0, 3) == 0) begin
        pending   = 1;
        DBG_REQ   = 1;
        DBG_WE    = $urandom_range(0, 2) == 0;
        DBG_ADDR  = 10'($urandom_range(0, 15));
        DBG_WDATA = DATA_W'($urandom);
      end
    end
    RST = 0;
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
